// File: rtl/pixel_byte_serializer.sv
// pixel_byte_serializer: buffers 24-bit RGB pixels in a small FIFO and emits them as R, G, B bytes,
// counting pixels per frame and pulsing frame_done after the last byte of each frame.
module pixel_byte_serializer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_PIXELS = 4096
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [23:0]                   data_in,
    input  logic                          valid_in,
    output logic                          ready_in,
    output logic [7:0]                    data_out,
    output logic                          valid_out,
    input  logic                          ready_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_PIXELS);

    typedef enum logic {EMPTY, SEND} state_t;

    state_t        state, state_n;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [23:0]   pixel, pixel_n;
    logic [1:0]    idx, idx_n;
    logic [CW-1:0] frame_cnt;
    logic          push, pop, last_hs;

    assign ready_in   = count != (AW+1)'(FIFO_DEPTH);
    assign fifo_count = count;
    assign push       = valid_in && ready_in;
    assign valid_out  = state == SEND;
    assign data_out   = state != SEND ? 8'h00 :
                        idx == 2'd0   ? pixel[23:16] :
                        idx == 2'd1   ? pixel[15:8]  : pixel[7:0];

    // The next pixel is popped on the same edge as the B handshake so bytes stay back-to-back.
    always_comb begin
        state_n = state;
        pixel_n = pixel;
        idx_n   = idx;
        pop     = 1'b0;
        last_hs = 1'b0;
        if (state == EMPTY) begin
            pop     = count != '0;
            state_n = count != '0 ? SEND : EMPTY;
        end else if (ready_out) begin
            idx_n   = idx + 2'd1;
            last_hs = idx == 2'd2;
            pop     = last_hs && count != '0;
            state_n = last_hs && count == '0 ? EMPTY : SEND;
        end
        if (pop) begin
            pixel_n = mem[rd_ptr];
            idx_n   = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= EMPTY;
            pixel      <= '0;
            idx        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            pixel      <= pixel_n;
            idx        <= idx_n;
            wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count      <= count + (AW+1)'(push) - (AW+1)'(pop);
            frame_done <= last_hs && frame_cnt == CW'(FRAME_PIXELS - 1);
            if (last_hs)
                frame_cnt <= frame_cnt == CW'(FRAME_PIXELS - 1) ? '0 : frame_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_pixel_byte_serializer.sv
// tb_pixel_byte_serializer: directed scenarios with a byte scoreboard and a cycle model of the FIFO,
// serializer occupancy and frame pulse.
module tb_pixel_byte_serializer;
    localparam int FD = 4;
    localparam int FP = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [23:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_out = 1'b0;
    logic        ready_in, valid_out, frame_done;
    logic [7:0]  data_out;
    logic [2:0]  fifo_count;

    pixel_byte_serializer #(.FIFO_DEPTH(FD), .FRAME_PIXELS(FP)) dut (
        .clk(clk), .resetn(resetn), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
        .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
        .fifo_count(fifo_count), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int         total = 0, bad = 0;
    logic [7:0] q[$];
    int         fd_at[$];
    int         bidx, pix, m_cnt, nbytes;
    bit         m_loaded, exp_fd, stall;
    logic [7:0] prev_d;

    function automatic logic [23:0] px(input int i);
        return 24'(24'h102030 + i * 24'h010101);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs at the falling edge, advance the model, return 1ns after the rising edge.
    task automatic cyc();
        bit hs, third, push, pop;
        @(negedge clk);
        if (frame_done) fd_at.push_back(nbytes);
        chk("frame_done", frame_done, exp_fd);
        chk("fifo_count", fifo_count, m_cnt);
        chk("ready_in", ready_in, m_cnt != FD);
        chk("valid_out", valid_out, m_loaded);
        if (stall) chk("hold", {valid_out, data_out}, {1'b1, prev_d});
        hs    = valid_out && ready_out;
        third = hs && bidx == 2;
        push  = valid_in && ready_in;
        exp_fd = 1'b0;
        if (hs) begin
            nbytes++;
            total++;
            assert (q.size() != 0) else begin
                bad++;
                $error("FAIL extra_byte observed=%0h expected=none", data_out);
            end
            if (q.size() != 0) chk("byte", data_out, q.pop_front());
            if (third) begin
                bidx = 0;
                exp_fd = pix == FP - 1;
                pix = pix == FP - 1 ? 0 : pix + 1;
            end else bidx++;
        end
        pop = m_cnt != 0 && (!m_loaded || third);
        if (push) begin
            q.push_back(data_in[23:16]);
            q.push_back(data_in[15:8]);
            q.push_back(data_in[7:0]);
        end
        m_cnt    = m_cnt + int'(push) - int'(pop);
        m_loaded = pop ? 1'b1 : third ? 1'b0 : m_loaded;
        stall    = valid_out && !ready_out;
        prev_d   = data_out;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        q.delete();
        fd_at.delete();
        bidx = 0; pix = 0; m_cnt = 0; nbytes = 0;
        m_loaded = 1'b0; exp_fd = 1'b0; stall = 1'b0;
    endtask

    task automatic push_px(input logic [23:0] d);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        valid_in = 1'b1;
        data_in = d;
        while (!acc && guard < 20) begin
            acc = ready_in;
            cyc();
            guard++;
        end
        valid_in = 1'b0;
        chk("push_timeout", acc, 1'b1);
    endtask

    task automatic drain(input int n);
        repeat (n) cyc();
        chk("drained", q.size(), 0);
    endtask

    initial begin
        bit acc;
        int minc, maxc, gaps, base;
        do_reset();
        chk("rst_ready_in", ready_in, 1'b1);
        chk("rst_valid_out", valid_out, 1'b0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_fifo_count", fifo_count, 3'd0);
        chk("rst_frame_done", frame_done, 1'b0);

        // single pixel, 2-edge latency
        ready_out = 1'b1;
        valid_in = 1'b1;
        data_in = 24'h123456;
        cyc();
        valid_in = 1'b0;
        chk("lat_edge1", valid_out, 1'b0);
        cyc();
        chk("lat_edge2", valid_out, 1'b1);
        chk("first_r", data_out, 8'h12);
        cyc();
        chk("second_g", data_out, 8'h34);
        cyc();
        chk("third_b", data_out, 8'h56);
        cyc();
        chk("idle_after", valid_out, 1'b0);
        drain(2);

        // backpressure on the G byte
        push_px(24'hA1B2C3);
        cyc();
        chk("bp_r", data_out, 8'hA1);
        cyc();
        ready_out = 1'b0;
        repeat (5) cyc();
        chk("bp_hold", {valid_out, data_out}, {1'b1, 8'hB2});
        ready_out = 1'b1;
        cyc();
        chk("bp_after", data_out, 8'hC3);
        drain(4);

        // FIFO fill under backpressure
        ready_out = 1'b0;
        base = nbytes;
        for (int i = 1; i <= 5; i++) push_px(px(i));
        valid_in = 1'b1;
        data_in = px(6);
        repeat (3) cyc();
        chk("fill_count", fifo_count, 3'd4);
        chk("fill_ready_in", ready_in, 1'b0);
        chk("fill_r1", data_out, px(1) >> 16);
        ready_out = 1'b1;
        acc = 1'b0;
        for (int g = 0; g < 10 && !acc; g++) begin
            acc = ready_in;
            cyc();
        end
        valid_in = 1'b0;
        chk("px6_taken", acc, 1'b1);
        drain(25);
        chk("fill_bytes", nbytes - base, 18);

        // back-to-back at full
        ready_out = 1'b0;
        valid_in = 1'b1;
        data_in = px(7);
        repeat (8) begin
            acc = ready_in;
            cyc();
            if (acc) data_in = data_in + 24'h010101;
        end
        chk("full_count", fifo_count, 3'd4);
        ready_out = 1'b1;
        minc = 99; maxc = 0; gaps = 0;
        repeat (24) begin
            acc = ready_in;
            cyc();
            if (acc) data_in = data_in + 24'h010101;
            minc = fifo_count < minc ? int'(fifo_count) : minc;
            maxc = fifo_count > maxc ? int'(fifo_count) : maxc;
            gaps += int'(!valid_out);
        end
        valid_in = 1'b0;
        chk("b2b_min", minc, 3);
        chk("b2b_max", maxc, 4);
        chk("b2b_gaps", gaps, 0);
        drain(25);

        // frame wrap: 8 pixels, pulses after bytes 12 and 24
        do_reset();
        for (int i = 0; i < 8; i++) push_px(px(20 + i));
        drain(20);
        chk("fd_pulses", fd_at.size(), 2);
        chk("fd_first", fd_at.size() > 0 ? fd_at[0] : -1, 12);
        chk("fd_second", fd_at.size() > 1 ? fd_at[1] : -1, 24);

        // reset mid-pixel with a non-zero frame count and 2 pixels queued
        push_px(px(30));
        drain(6);
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) push_px(px(40 + i));
        cyc();
        ready_out = 1'b1;
        cyc();
        chk("mid_g", data_out, (px(40) >> 8) & 24'hFF);
        chk("mid_count", fifo_count, 3'd2);
        do_reset();
        chk("mid_rst_valid", valid_out, 1'b0);
        chk("mid_rst_count", fifo_count, 3'd0);
        chk("mid_rst_ready", ready_in, 1'b1);
        push_px(24'hDEADBE);
        cyc();
        chk("post_rst_r", data_out, 8'hDE);
        for (int i = 0; i < 3; i++) push_px(px(50 + i));
        drain(15);
        chk("restart_pulses", fd_at.size(), 1);
        chk("restart_at", fd_at.size() > 0 ? fd_at[0] : -1, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pixel_byte_serializer.md
# pixel_byte_serializer

Converts 24-bit RGB pixels from the median filter output stream into a byte stream for the UART transmit path. It is the inverse of the 8-to-24 input width converter. A small pixel FIFO absorbs filter bursts. Each pixel is emitted as three bytes, R ([23:16]) first, then G ([15:8]), then B ([7:0]), over a valid/ready handshake. The block also counts pixels per frame and pulses a flag when the last byte of a frame has been sent.

## Interface
- FIFO_DEPTH, default 4: pixel FIFO entries; a power of two, at least 2.
- FRAME_PIXELS, default 4096: pixels per frame (64x64).
- clk  in  1  clock, rising-edge.
- resetn  in  1  reset, synchronous, active-low.
- data_in  in  24  pixel from the median filter; {R,G,B}.
- valid_in  in  1  data_in is valid.
- ready_in  out  1  block can accept a pixel; a transfer happens when valid_in && ready_in at a rising edge.
- data_out  out  8  byte toward the UART TX.
- valid_out  out  1  data_out is valid.
- ready_out  in  1  downstream accepts the byte; a transfer happens when valid_out && ready_out at a rising edge.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of pixels held in the FIFO (the serializer register is excluded).
- frame_done  out  1  one-cycle pulse after the last byte of a frame is accepted.

## Operation
- FIFO
  - Circular buffer with write pointer, read pointer and count register.
  - ready_in = (fifo_count != FIFO_DEPTH). It is decoded from the registered count only; there is no pass-through from the read side.
  - A push and a pop in the same cycle leave the count unchanged.
  - A push while full cannot occur, because ready_in is low.
  - Pointers wrap modulo FIFO_DEPTH.
- Serializer: holds a 24-bit pixel register, a 2-bit byte index (0, 1, 2) and a loaded flag. It has two states.
  - EMPTY
    - valid_out = 0.
    - If fifo_count != 0: pop the FIFO into the pixel register, set index = 0, go to SEND.
  - SEND
    - valid_out = 1.
    - data_out = pixel[23:16], pixel[15:8] or pixel[7:0] for index 0, 1, 2.
    - On a handshake with index < 2: index increments.
    - On a handshake with index == 2 and the FIFO non-empty: pop the next pixel in the same edge and set index = 0, staying in SEND. There is no bubble between pixels.
    - On a handshake with index == 2 and the FIFO empty: go to EMPTY.
- Output stability: while valid_out = 1 and ready_out = 0, data_out and valid_out do not change.
- Frame counter
  - Counts 0 to FRAME_PIXELS-1 and advances on each index-2 handshake.
  - On the handshake of byte index 2 while the count is FRAME_PIXELS-1, the counter wraps to 0 and frame_done is high for the next cycle only.
- Width rules: the frame counter is $clog2(FRAME_PIXELS) bits. Pixel content is passed through unmodified; no arithmetic is applied to it.

## Timing
- Reset (resetn = 0 at a rising edge) clears all state. Values after reset:
  - ready_in = 1, valid_out = 0, data_out = 8'h00, fifo_count = 0, frame_done = 0.
  - Pointers, byte index and frame counter are 0.
  - Reset mid-pixel discards the partial pixel and all FIFO contents; the next accepted pixel starts at the R byte.
- Latency: a pixel accepted at edge t0 is in the FIFO after t0. It loads at t1 when the serializer is EMPTY, so valid_out is high with the R byte in the cycle after t1.
  - Minimum: 2 edges from accept to the first byte presented.
  - When SEND is already busy, the pixel is loaded on the index-2 handshake edge of the previous pixel.
- Throughput with ready_out held at 1: one byte per clock, three clocks per pixel, continuous across pixels.
- All outputs are registered, or decoded only from registers. There is no combinational path from valid_in to valid_out or from ready_out to ready_in.
- frame_done asserts in the cycle after the final handshake and is never high for two consecutive cycles.

## Test plan
- Single pixel: push 24'h123456 with ready_out = 1.
  - ready_in stays 1.
  - valid_out rises 2 edges after the push.
  - data_out reads 8'h12, 8'h34, 8'h56 on three consecutive cycles, then valid_out = 0.
- Backpressure: push 24'hA1B2C3 and drop ready_out for 5 cycles while 8'hB2 is presented.
  - data_out holds 8'hB2 and valid_out holds 1 throughout.
  - After release, 8'hB2 then 8'hC3 are sent; no byte is lost or duplicated.
- FIFO fill: ready_out = 0, valid_in = 1, pixels 1 to 6 offered.
  - One pixel is loaded into the serializer, then four more enter the FIFO.
  - ready_in = 0 with fifo_count = 4 and pixel 6 held.
  - Release ready_out: exactly 18 bytes appear, in order.
- Back-to-back at full: with the FIFO full and ready_out = 1, keep valid_in high.
  - Each pop re-asserts ready_in one cycle later.
  - fifo_count oscillates between 3 and 4.
  - No gap appears in valid_out.
- Frame wrap: FRAME_PIXELS = 4, stream 8 pixels with ready_out = 1.
  - frame_done pulses exactly twice, in the cycles after byte 12 and after byte 24.
- Reset mid-operation: assert resetn = 0 for one edge while the G byte of a pixel is presented and 2 pixels are queued.
  - Afterwards valid_out = 0, fifo_count = 0, ready_in = 1.
  - The next pushed pixel emits its R byte first, and frame_done counting restarts at 0.
